// File: rtl/bomb_timer_pkg.sv
// Shared state encoding and time constants for the bomb_timer countdown core.
// Pure declarations: no latency and no flow control.
package bomb_timer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUN      = 2'b01,
        DEFUSED  = 2'b10,
        EXPLODED = 2'b11
    } timer_state_t;

    localparam int SEC_PER_MIN = 60;
    localparam int MAX_MIN     = 99;

endpackage

// File: rtl/bin2bcd99.sv
// Combinational 0..99 binary to two-digit {tens, ones} BCD converter.
// Zero latency; no flow control. Out-of-range inputs clamp to 99.
module bin2bcd99
    import bomb_timer_pkg::*;
(
    input  logic [6:0] i_bin,
    output logic [7:0] o_bcd
);

    logic [6:0] w_val;

    assign w_val = (i_bin > 7'(MAX_MIN)) ? 7'(MAX_MIN) : i_bin;
    assign o_bcd = {4'(w_val / 7'd10), 4'(w_val % 7'd10)};

endmodule

// File: rtl/bomb_timer.sv
// MM:SS defuse-game countdown; outputs registered or decoded from registers, 1-cycle input response.
// No backpressure (pulse inputs). Define PENALTY_EN to make wrong_p subtract PENALTY_SEC.
module bomb_timer
    import bomb_timer_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int INIT_MIN    = 5,
    parameter int INIT_SEC    = 0,
    parameter int PENALTY_SEC = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_p,
    input  logic       defuse_p,
    input  logic       wrong_p,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       defused,
    output logic       exploded,
    output logic       tick
);

    localparam int         PW         = $clog2(TICK_DIV);
    localparam logic [6:0] LP_MIN0    = 7'(INIT_MIN);
    localparam logic [5:0] LP_SEC0    = 6'(INIT_SEC);
    localparam logic [5:0] LP_PEN     = 6'(PENALTY_SEC);
    localparam logic [5:0] LP_BORROW  = 6'(SEC_PER_MIN - PENALTY_SEC);
    localparam logic [5:0] LP_SEC_MAX = 6'(SEC_PER_MIN - 1);

    timer_state_t  r_state, w_state_nxt;
    logic [6:0]    r_min, w_min_nxt;
    logic [5:0]    r_sec, w_sec_nxt;
    logic [PW-1:0] r_presc, w_presc_nxt;
    logic          r_tick, w_tick_nxt;
    logic          w_wrap;
    logic          w_pen;

    assign w_wrap = (r_presc == PW'(TICK_DIV - 1));

`ifdef PENALTY_EN
    assign w_pen = wrong_p;
`else
    logic w_unused_wrong;
    assign w_unused_wrong = wrong_p;
    assign w_pen          = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_min   <= LP_MIN0;
            r_sec   <= LP_SEC0;
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_min   <= w_min_nxt;
            r_sec   <= w_sec_nxt;
            r_presc <= w_presc_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;
        w_presc_nxt = r_presc;
        w_tick_nxt  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start_p) begin
                    w_state_nxt = RUN;
                    w_presc_nxt = '0;
                end
            end
            RUN: begin
                w_presc_nxt = w_wrap ? '0 : r_presc + PW'(1);
                if (defuse_p) begin
                    w_state_nxt = DEFUSED;
                end else begin
                    // A penalty landing on a prescaler wrap replaces that second's decrement.
                    w_tick_nxt = w_wrap;
                    if (w_pen) begin
                        if (r_sec >= LP_PEN) begin
                            w_sec_nxt = r_sec - LP_PEN;
                        end else if (r_min != '0) begin
                            w_min_nxt = r_min - 7'd1;
                            w_sec_nxt = r_sec + LP_BORROW;
                        end else begin
                            w_sec_nxt = '0;
                        end
                    end else if (w_wrap) begin
                        if (r_sec != '0) begin
                            w_sec_nxt = r_sec - 6'd1;
                        end else if (r_min != '0) begin
                            w_min_nxt = r_min - 7'd1;
                            w_sec_nxt = LP_SEC_MAX;
                        end
                    end
                    if (w_min_nxt == '0 && w_sec_nxt == '0) begin
                        w_state_nxt = EXPLODED;
                    end
                end
            end
            DEFUSED, EXPLODED: begin
                if (start_p) begin
                    w_state_nxt = IDLE;
                    w_min_nxt   = LP_MIN0;
                    w_sec_nxt   = LP_SEC0;
                    w_presc_nxt = '0;
                end
            end
        endcase
    end

    bin2bcd99 u_min_bcd (
        .i_bin (r_min),
        .o_bcd (min_bcd)
    );

    bin2bcd99 u_sec_bcd (
        .i_bin ({1'b0, r_sec}),
        .o_bcd (sec_bcd)
    );

    assign running  = (r_state == RUN);
    assign defused  = (r_state == DEFUSED);
    assign exploded = (r_state == EXPLODED);
    assign tick     = r_tick;

endmodule

// File: tb/tb_bomb_timer.sv
// Directed bench: 00:03 timer (dut) plus a 01:00 timer (dut_b) sharing all inputs.
module tb_bomb_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_p;
    logic       defuse_p;
    logic       wrong_p;
    logic [7:0] min_bcd, sec_bcd;
    logic       running, defused, exploded, tick;
    logic [7:0] b_min_bcd, b_sec_bcd;
    logic [3:0] b_unused_flags;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [3:0] F_IDLE  = 4'b0000;
    localparam logic [3:0] F_RUN   = 4'b1000;
    localparam logic [3:0] F_RUN_T = 4'b1001;
    localparam logic [3:0] F_DEF   = 4'b0100;
    localparam logic [3:0] F_EXP   = 4'b0010;
    localparam logic [3:0] F_EXP_T = 4'b0011;
    localparam logic [3:0] M_ALL   = 4'b1111;
    localparam logic [3:0] M_NOTK  = 4'b1110;

    typedef struct {
        string      tag;
        logic [7:0] mn;
        logic [7:0] sc;
        logic [3:0] fl;
        logic [3:0] msk;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];

    always #5 clk = ~clk;

    bomb_timer #(.TICK_DIV(4), .INIT_MIN(0), .INIT_SEC(3), .PENALTY_SEC(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .start_p  (start_p),
        .defuse_p (defuse_p),
        .wrong_p  (wrong_p),
        .min_bcd  (min_bcd),
        .sec_bcd  (sec_bcd),
        .running  (running),
        .defused  (defused),
        .exploded (exploded),
        .tick     (tick)
    );

    bomb_timer #(.TICK_DIV(4), .INIT_MIN(1), .INIT_SEC(0), .PENALTY_SEC(2)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .start_p  (start_p),
        .defuse_p (defuse_p),
        .wrong_p  (wrong_p),
        .min_bcd  (b_min_bcd),
        .sec_bcd  (b_sec_bcd),
        .running  (b_unused_flags[3]),
        .defused  (b_unused_flags[2]),
        .exploded (b_unused_flags[1]),
        .tick     (b_unused_flags[0])
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic s, input logic d, input logic w);
        start_p  = s;
        defuse_p = d;
        wrong_p  = w;
        @(negedge clk);
        start_p  = 1'b0;
        defuse_p = 1'b0;
        wrong_p  = 1'b0;
    endtask

    task automatic expect_a(input string t, input logic [7:0] m, input logic [7:0] s,
                            input logic [3:0] f, input logic [3:0] k);
        exp_t e;
        e.tag = t; e.mn = m; e.sc = s; e.fl = f; e.msk = k;
        sb_a.push_back(e);
    endtask

    task automatic expect_b(input string t, input logic [7:0] m, input logic [7:0] s);
        exp_t e;
        e.tag = t; e.mn = m; e.sc = s; e.fl = 4'b0; e.msk = 4'b0;
        sb_b.push_back(e);
    endtask

    task automatic check_a();
        exp_t       e;
        logic [3:0] obs;
        if (sb_a.size() == 0) begin
            miscompares++;
            $error("FAIL sb_a_empty observed=0 entries expected>=1");
            return;
        end
        e   = sb_a.pop_front();
        obs = {running, defused, exploded, tick};
        vectors++;
        assert (min_bcd === e.mn) else begin
            miscompares++;
            $error("FAIL %s min_bcd observed=%h expected=%h", e.tag, min_bcd, e.mn);
        end
        vectors++;
        assert (sec_bcd === e.sc) else begin
            miscompares++;
            $error("FAIL %s sec_bcd observed=%h expected=%h", e.tag, sec_bcd, e.sc);
        end
        vectors++;
        assert ((obs & e.msk) === (e.fl & e.msk)) else begin
            miscompares++;
            $error("FAIL %s flags{run,def,exp,tick} observed=%b expected=%b mask=%b",
                   e.tag, obs, e.fl, e.msk);
        end
    endtask

    task automatic check_b();
        exp_t e;
        if (sb_b.size() == 0) begin
            miscompares++;
            $error("FAIL sb_b_empty observed=0 entries expected>=1");
            return;
        end
        e = sb_b.pop_front();
        vectors++;
        assert ({b_min_bcd, b_sec_bcd} === {e.mn, e.sc}) else begin
            miscompares++;
            $error("FAIL %s b_time observed=%h:%h expected=%h:%h",
                   e.tag, b_min_bcd, b_sec_bcd, e.mn, e.sc);
        end
    endtask

    initial begin
        reset    = 1'b0;
        start_p  = 1'b0;
        defuse_p = 1'b0;
        wrong_p  = 1'b0;
        step(2);
        expect_a("in_reset", 8'h00, 8'h03, F_IDLE, M_ALL);
        expect_b("in_reset_b", 8'h01, 8'h00);
        check_a(); check_b();

        reset = 1'b1;
        expect_a("idle10", 8'h00, 8'h03, F_IDLE, M_ALL);
        step(10); check_a();
        expect_a("idle_defuse", 8'h00, 8'h03, F_IDLE, M_ALL);
        pulse(0, 1, 0); check_a();
        expect_a("idle_wrong", 8'h00, 8'h03, F_IDLE, M_ALL);
        pulse(0, 0, 1); check_a();

        // Countdown to explosion; dut_b shows the minute borrow on the first tick.
        expect_a("start", 8'h00, 8'h03, F_RUN, M_ALL);
        pulse(1, 0, 0); check_a();
        expect_a("pre_tick1", 8'h00, 8'h03, F_RUN, M_ALL);
        step(3); check_a();
        expect_a("tick1", 8'h00, 8'h02, F_RUN_T, M_ALL);
        expect_b("borrow_b", 8'h00, 8'h59);
        step(1); check_a(); check_b();
        expect_a("post_tick1", 8'h00, 8'h02, F_RUN, M_ALL);
        step(1); check_a();
        expect_a("tick2", 8'h00, 8'h01, F_RUN_T, M_ALL);
        step(3); check_a();
        expect_a("explode", 8'h00, 8'h00, F_EXP_T, M_ALL);
        step(4); check_a();
        expect_a("explode_hold", 8'h00, 8'h00, F_EXP, M_ALL);
        step(20); check_a();
        expect_a("reload", 8'h00, 8'h03, F_IDLE, M_ALL);
        pulse(1, 0, 0); check_a();
        expect_a("reload_hold", 8'h00, 8'h03, F_IDLE, M_ALL);
        step(6); check_a();

        // Defuse on the same edge as the 01 -> 00 tick.
        expect_a("start2", 8'h00, 8'h03, F_RUN, M_ALL);
        pulse(1, 0, 0); check_a();
        expect_a("pre_final", 8'h00, 8'h01, F_RUN, M_ALL);
        step(11); check_a();
        expect_a("defuse_wins", 8'h00, 8'h01, F_DEF, M_NOTK);
        pulse(0, 1, 0); check_a();
        expect_a("defuse_hold", 8'h00, 8'h01, F_DEF, M_ALL);
        step(5); check_a();
        expect_a("restart_idle", 8'h00, 8'h03, F_IDLE, M_ALL);
        pulse(1, 0, 0); check_a();
        expect_a("restart_run", 8'h00, 8'h03, F_RUN, M_ALL);
        pulse(1, 0, 0); check_a();

        // Asynchronous reset while running at 00:02.
        expect_a("run_02", 8'h00, 8'h02, F_RUN_T, M_ALL);
        step(4); check_a();
        reset = 1'b0;
        #1;
        expect_a("async_reset", 8'h00, 8'h03, F_IDLE, M_ALL);
        expect_b("async_reset_b", 8'h01, 8'h00);
        check_a(); check_b();
        @(negedge clk);
        reset = 1'b1;
        expect_a("post_reset_idle", 8'h00, 8'h03, F_IDLE, M_ALL);
        step(6); check_a();

        // Wrong-wire penalty; dut_b exercises the borrow path from 01:00.
        expect_a("pen_start", 8'h00, 8'h03, F_RUN, M_ALL);
        pulse(1, 0, 0); check_a();
`ifdef PENALTY_EN
        expect_a("pen1", 8'h00, 8'h01, F_RUN, M_ALL);
        expect_b("pen1_b", 8'h00, 8'h58);
`else
        expect_a("pen1", 8'h00, 8'h03, F_RUN, M_ALL);
        expect_b("pen1_b", 8'h01, 8'h00);
`endif
        pulse(0, 0, 1); check_a(); check_b();
`ifdef PENALTY_EN
        expect_a("pen2", 8'h00, 8'h00, F_EXP, M_ALL);
        expect_b("pen2_b", 8'h00, 8'h56);
`else
        expect_a("pen2", 8'h00, 8'h03, F_RUN, M_ALL);
        expect_b("pen2_b", 8'h01, 8'h00);
`endif
        pulse(0, 0, 1); check_a(); check_b();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bomb_timer.md
# bomb_timer

Countdown core of the defuse game. Consumes the one-cycle button pulses produced by the upstream button one-pulse shapers (start, defuse, wrong-wire) and runs an MM:SS countdown that ends in either DEFUSED or EXPLODED. Its BCD outputs feed the seven-segment display driver, and its status flags feed the game-result logic.

## Interface
- TICK_DIV, 50_000_000, clk cycles per countdown second; minimum 2.
- INIT_MIN, 5, reload minutes; range 0..99.
- INIT_SEC, 0, reload seconds; range 0..59; INIT_MIN:INIT_SEC must not be 00:00.
- PENALTY_SEC, 10, seconds removed per wrong-wire pulse; range 1..59.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- start_p  in  1  one-cycle pulse; arms the countdown or reloads it.
- defuse_p  in  1  one-cycle pulse; correct wire cut.
- wrong_p  in  1  one-cycle pulse; wrong wire cut (penalty).
- min_bcd  out  8  minutes as {tens, ones} BCD.
- sec_bcd  out  8  seconds as {tens, ones} BCD.
- running  out  1  high while in RUN.
- defused  out  1  high while in DEFUSED.
- exploded  out  1  high while in EXPLODED.
- tick  out  1  one-cycle pulse on each countdown decrement.

## Operation
- State is held as binary `min` (0..99, 7 bits) and `sec` (0..59, 6 bits). The BCD outputs are combinational conversions of these registers.
- FSM states: IDLE, RUN, DEFUSED, EXPLODED.
- IDLE:
  - start_p -> RUN, prescaler cleared to 0.
  - defuse_p and wrong_p are ignored.
- RUN:
  - The prescaler increments every cycle.
  - When the prescaler equals TICK_DIV-1, it wraps to 0, time decrements by 1 s, and tick=1 the next cycle.
  - Decrement rules: sec>0 -> sec-1; sec=0 with min>0 -> min-1, sec=59. If the result is 00:00 -> EXPLODED.
  - wrong_p (only when PENALTY_EN is defined):
    - sec>=PENALTY_SEC -> sec-PENALTY_SEC.
    - Otherwise, if min>0 -> min-1, sec+60-PENALTY_SEC.
    - Otherwise saturate to 00:00.
    - A result of 00:00 -> EXPLODED.
  - defuse_p -> DEFUSED; time freezes at its current value.
  - start_p is ignored.
- DEFUSED and EXPLODED: time is frozen. start_p reloads INIT_MIN:INIT_SEC and returns to IDLE; a second start_p is needed to run again.
- Priority within one RUN cycle: defuse_p > wrong_p > prescaler tick.
  - Defuse wins even if a tick would reach 00:00 in the same cycle.
  - When a penalty and a tick coincide, only the penalty is applied. The prescaler still wraps, and tick still pulses.

## Timing
- All outputs are registered or derived combinationally from registers. There is no input-to-output combinational path.
- Reset values: state=IDLE, min=INIT_MIN, sec=INIT_SEC, prescaler=0, tick=0, running=0, defused=0, exploded=0.
- start_p sampled at edge N: running=1 after edge N. The first decrement and tick=1 appear after edge N+TICK_DIV.
- defuse_p / wrong_p sampled at edge N: the state or time change is visible after edge N.
- Reset asserted mid-RUN returns all registers to reset values asynchronously. No pulse is remembered.

## Configuration
- PENALTY_EN defined: wrong_p applies the PENALTY_SEC subtraction as described above.
- PENALTY_EN undefined: wrong_p is ignored in every state, and PENALTY_SEC is unused. All other behaviour is identical.

## Structure
- Package bomb_timer_pkg holds:
  - the state enum `timer_state_t` (IDLE=2'b00, RUN=2'b01, DEFUSED=2'b10, EXPLODED=2'b11);
  - constants SEC_PER_MIN=60 and MAX_MIN=99.
- Sub-module bin2bcd99 is a combinational 7-bit binary (0..99) to 8-bit BCD converter. It is instantiated twice, once for minutes and once for seconds.
- Prescaler width is $clog2(TICK_DIV).

## Test plan
All scenarios use TICK_DIV=4, INIT_MIN=0, INIT_SEC=3, PENALTY_SEC=2 unless stated otherwise.
- **Reset / idle:** release reset, idle 10 cycles -> min_bcd=8'h00, sec_bcd=8'h03, running=0, tick=0. Pulse defuse_p -> no change.
- **Countdown to explode:** start_p -> running=1. sec_bcd reads 02, 01, 00 at 4-cycle spacing, with tick pulsing each time. At 00 -> exploded=1, running=0. Time holds at 00:00 for 20 cycles.
- **Minute borrow:** with INIT_MIN=1, INIT_SEC=0, start -> after 4 cycles min_bcd=8'h00, sec_bcd=8'h59.
- **Penalty:** with PENALTY_EN defined, start and then wrong_p at 00:03 -> 00:01. A second wrong_p -> 00:00 and exploded=1. Without PENALTY_EN, the same stimulus -> time unchanged.
- **Priority and restart:** defuse_p in the same cycle as the final tick (01 -> 00) -> defused=1, sec_bcd=8'h01. Then start_p -> IDLE with 00:03. A second start_p -> running=1.
- **Reset mid-run:** assert reset for 1 cycle while running at 00:02 -> immediate IDLE, 00:03, all flags 0.
